video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing and framebuffer-address generator; successor to the fixed 640x480 sync generator. It generates configurable porch, sync and active timing, and selectable sync polarity. It also produces integer pixel replication (1x/2x/4x/8x) and a multiplier-free framebuffer read address. A pixel-enable input lets it run from a faster system clock. Sync and active outputs are delayed to match the video-memory read latency. It sits between the pixel clock domain and the video memory read port inside the VGA controller.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_BACK`, 48, back porch in pixels
- `H_FRONT`, 16, front porch in pixels
- `H_SYNC`, 96, sync width in pixels
- `V_ACTIVE`, 480, visible lines
- `V_BACK`, 33, back porch in lines
- `V_FRONT`, 10, front porch in lines
- `V_SYNC`, 2, sync width in lines
- `SYNC_POL`, 0, sync asserted level (0 = active-low)
- `SCALE_LOG2`, 2, pixel replication exponent, 0..3
- `RD_LATENCY`, 1, memory read latency in pixel steps, 0..3
- `ADDR_W`, 15, framebuffer address width
- `clk  in  1`  pixel or system clock
- `rst  in  1`  reset; one clock, asynchronous, active-high
- `pix_en  in  1`  advance one pixel position this cycle
- `fb_addr  out  ADDR_W`  framebuffer read address
- `fb_rd_en  out  1`  read strobe; high in active area on pix_en cycles
- `h_sync  out  1`  horizontal sync, delayed by RD_LATENCY
- `v_sync  out  1`  vertical sync, delayed by RD_LATENCY
- `active  out  1`  visible-pixel flag, delayed by RD_LATENCY
- `line_start  out  1`  one-cycle pulse, first active pixel of each line, delayed
- `frame_start  out  1`  one-cycle pulse, first active pixel of each frame, delayed

## Operation
- **Line and frame order.** Each line is back porch, active, front porch, sync. Each frame uses the same order in lines.
- **Totals.** `H_TOTAL` is the sum of the four H parameters. `V_TOTAL` is the sum of the four V parameters.
- **Counters.**
  - `h_cnt` runs 0..H_TOTAL-1 and advances only when `pix_en` is 1.
  - `v_cnt` runs 0..V_TOTAL-1 and advances when `h_cnt` wraps.
  - Both wrap to 0, with no gap cycle.
- **Active area.** Active when `h_cnt` is in [H_BACK, H_BACK+H_ACTIVE) and `v_cnt` is in [V_BACK, V_BACK+V_ACTIVE).
- **Horizontal sync.** Asserted while `h_cnt` ≥ H_BACK+H_ACTIVE+H_FRONT.
- **Vertical sync.** Asserted while `v_cnt` ≥ V_BACK+V_ACTIVE+V_FRONT, for whole lines.
- **Address generation.** Framebuffer width is `FB_W` = H_ACTIVE>>SCALE_LOG2.
  - The address equals (y>>S)*FB_W + (x>>S), where x and y are active-area coordinates.
  - It is built incrementally from a `row_base` register and a column register. No multiplier is used.
  - The column register increments after every 2^S active pixels.
  - At the end of each active line the column register resets to `row_base`.
  - `row_base` += FB_W at the end of an active line when y[S-1:0] is all ones; otherwise it is unchanged.
  - `row_base` clears to 0 at the frame wrap.
- **Address outside the active area.** `fb_addr` holds 0.
- **Delay line.** A RD_LATENCY-deep shift register carries h_sync, v_sync, active, line_start and frame_start.
  - It shifts only on `pix_en`.
  - RD_LATENCY=0 means these outputs are registered but not delayed.
- **Reset values.**
  - Counters, `row_base`, column register and `fb_addr` are 0.
  - `fb_rd_en`, `active`, `line_start` and `frame_start` are 0.
  - `h_sync` and `v_sync` are at the inactive level (~SYNC_POL).
  - Every delay-line stage resets to the same inactive values.
- **Reset mid-frame.** Asynchronous reset forces all of the above immediately. Timing restarts at h=0, v=0 on the first `pix_en` after release; no partial line is emitted.

## Timing
- All outputs are registered; there are no combinational paths from `pix_en` to any output.
- **Address latency.** `fb_addr`/`fb_rd_en` for position (h, v) are valid in the cycle after the `pix_en` that moved the counters to (h, v).
- **Video output latency.** `h_sync`, `v_sync`, `active` and the strobes for that position appear RD_LATENCY `pix_en` steps after `fb_addr`.
- **Memory requirement.** Memory output must hold its value while `pix_en` is 0.
- **Strobe width.** With `pix_en` held high, `line_start` and `frame_start` are one clock wide. With gated `pix_en`, they last exactly one pixel step and deassert on the next `pix_en`.
- **Coincident pulses.** `frame_start` coincides with `line_start` on the first active line.
- **Simultaneous wraps.** When h and v wrap together at (H_TOTAL-1, V_TOTAL-1), both counters go to 0 in the same cycle and `row_base` clears.
- **Elaboration-time checks.** Elaboration fails if any of the following hold:
  - H_ACTIVE is not a multiple of 2^S;
  - FB_W*(V_ACTIVE>>S) > 2^ADDR_W;
  - counter widths are below clog2 of the totals.

## Structure
- **Shared package `video_pkg`:**
  - the 640x480@60 default constants;
  - a 800x600 preset;
  - the `sync_level_f(active, pol)` function;
  - the `clog2`-derived counter width localparams.
- **Sub-module `video_delay_line`:** parametrised depth and width, shift on enable, async reset to a parameter value.

## Test plan
- **Reference timing.** Defaults with `pix_en`=1: h_sync low for exactly 96 clocks per 800-clock line; v_sync low for 2 lines per 525-line frame; active high for 640x480.
- **Replication address.** Small config (H 8/2/1/1, V 4/1/1/1, S=1): fb_addr sequence is 0,0,1,1,2,2,3,3 on lines 0 and 1, and 4,4,5,5,6,6,7,7 on lines 2 and 3; `row_base` is 0 again in the next frame.
- **Pixel enable.** `pix_en` every 2nd cycle: outputs hold between enables; line period doubles to 2*H_TOTAL clocks; `fb_rd_en` is high only on enable cycles.
- **Latency and polarity.** RD_LATENCY=2 with SYNC_POL=1: `active` rises 2 pixel steps after the first nonzero-line `fb_rd_en`; sync pulses are high; `frame_start` and `line_start` coincide once per frame.
- **Reset mid-frame.** Reset asserted mid-frame at h=300, v=200: outputs go inactive asynchronously the same cycle; after release the first `frame_start` occurs at h=H_BACK, v=V_BACK of a fresh frame.
- **Frame wrap.** Counters held at h=H_TOTAL-1, v=V_TOTAL-1 with `pix_en`: both counters read 0 next cycle; v_sync deasserts together with the h wrap.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared raster presets, sync-level helper and the per-pixel signal bundle
package video_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_BACK + VGA_H_FRONT + VGA_H_SYNC;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_BACK + VGA_V_FRONT + VGA_V_SYNC;
  localparam int VGA_H_CNT_W  = $clog2(VGA_H_TOTAL);
  localparam int VGA_V_CNT_W  = $clog2(VGA_V_TOTAL);
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_BACK   = 88;
  localparam int SVGA_H_FRONT  = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_BACK   = 23;
  localparam int SVGA_V_FRONT  = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_H_TOTAL  = SVGA_H_ACTIVE + SVGA_H_BACK + SVGA_H_FRONT + SVGA_H_SYNC;
  localparam int SVGA_V_TOTAL  = SVGA_V_ACTIVE + SVGA_V_BACK + SVGA_V_FRONT + SVGA_V_SYNC;
  localparam int SVGA_H_CNT_W  = $clog2(SVGA_H_TOTAL);
  localparam int SVGA_V_CNT_W  = $clog2(SVGA_V_TOTAL);
  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic active;
    logic line_start;
    logic frame_start;
  } vid_sig_t;
  function automatic logic sync_level_f(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction
endpackage

// File: rtl/video_delay_line.sv
// video_delay_line: enable-gated shift register with asynchronous reset to a fixed value
module video_delay_line #(
  parameter int DEPTH = 1,
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] sr_q, sr_d;
  always_comb begin
    sr_d = sr_q;
    if (en) begin
      sr_d[0] = d;
      for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= {DEPTH{RST_VAL}};
    else sr_q <= sr_d;
  end
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing with replicated, multiplier-free framebuffer addressing
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_BACK     = VGA_H_BACK,
  parameter int   H_FRONT    = VGA_H_FRONT,
  parameter int   H_SYNC     = VGA_H_SYNC,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_BACK     = VGA_V_BACK,
  parameter int   V_FRONT    = VGA_V_FRONT,
  parameter int   V_SYNC     = VGA_V_SYNC,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   SCALE_LOG2 = 2,
  parameter int   RD_LATENCY = 1,
  parameter int   ADDR_W     = 15,
  parameter int   H_CNT_W    = $clog2(H_ACTIVE + H_BACK + H_FRONT + H_SYNC),
  parameter int   V_CNT_W    = $clog2(V_ACTIVE + V_BACK + V_FRONT + V_SYNC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  output logic              h_sync,
  output logic              v_sync,
  output logic              active,
  output logic              line_start,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_BACK + H_FRONT + H_SYNC;
  localparam int V_TOTAL = V_ACTIVE + V_BACK + V_FRONT + V_SYNC;
  localparam int FB_W = H_ACTIVE >> SCALE_LOG2;
  localparam logic [H_CNT_W-1:0] H_LAST    = H_CNT_W'(H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT_LO  = H_CNT_W'(H_BACK);
  localparam logic [H_CNT_W-1:0] H_ACT_HI  = H_CNT_W'(H_BACK + H_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_SYNC_LO = H_CNT_W'(H_BACK + H_ACTIVE + H_FRONT);
  localparam logic [H_CNT_W-1:0] X_LAST    = H_CNT_W'(H_ACTIVE - 1);
  localparam logic [H_CNT_W-1:0] H_MASK    = H_CNT_W'((1 << SCALE_LOG2) - 1);
  localparam logic [V_CNT_W-1:0] V_LAST    = V_CNT_W'(V_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_LO  = V_CNT_W'(V_BACK);
  localparam logic [V_CNT_W-1:0] V_ACT_HI  = V_CNT_W'(V_BACK + V_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_SYNC_LO = V_CNT_W'(V_BACK + V_ACTIVE + V_FRONT);
  localparam logic [V_CNT_W-1:0] V_MASK    = V_CNT_W'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0]  FB_W_A    = ADDR_W'(FB_W);
  localparam vid_sig_t IDLE = '{h_sync: ~SYNC_POL, v_sync: ~SYNC_POL, default: 1'b0};
  if (H_ACTIVE % (1 << SCALE_LOG2) != 0) begin : g_bad_scale
    $error("H_ACTIVE must be a multiple of 2**SCALE_LOG2");
  end
  if (longint'(FB_W) * longint'(V_ACTIVE >> SCALE_LOG2) > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("framebuffer does not fit in ADDR_W bits");
  end
  if (H_CNT_W < $clog2(H_TOTAL) || V_CNT_W < $clog2(V_TOTAL)) begin : g_bad_cnt
    $error("counter width too small for the line or frame total");
  end
  logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d, h_n, x_n;
  logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d, v_n, y_n;
  logic [ADDR_W-1:0] col_q, col_d, row_base_q, row_base_d, fb_addr_q, fb_addr_d, row_next;
  logic started_q, started_d, fb_rd_en_q, fb_rd_en_d;
  logic h_last, v_last, act_n, line_end, wrap;
  vid_sig_t s0_q, s0_d, s_out;
  // started_q makes the first enabled step after reset land on (0,0) instead of (1,0)
  always_comb begin
    h_last = h_cnt_q == H_LAST;
    v_last = v_cnt_q == V_LAST;
    h_n = (!started_q || h_last) ? '0 : h_cnt_q + H_CNT_W'(1);
    v_n = !started_q ? '0 : !h_last ? v_cnt_q : v_last ? '0 : v_cnt_q + V_CNT_W'(1);
    x_n = h_n - H_ACT_LO;
    y_n = v_n - V_ACT_LO;
    act_n = h_n >= H_ACT_LO && h_n < H_ACT_HI && v_n >= V_ACT_LO && v_n < V_ACT_HI;
    line_end = act_n && x_n == X_LAST;
    wrap = h_n == '0 && v_n == '0;
    row_next = ((y_n & V_MASK) == V_MASK) ? row_base_q + FB_W_A : row_base_q;
    h_cnt_d = pix_en ? h_n : h_cnt_q;
    v_cnt_d = pix_en ? v_n : v_cnt_q;
    started_d = started_q | pix_en;
    col_d = !pix_en ? col_q : wrap ? '0 : line_end ? row_next :
            (act_n && (x_n & H_MASK) == H_MASK) ? col_q + ADDR_W'(1) : col_q;
    row_base_d = !pix_en ? row_base_q : wrap ? '0 : line_end ? row_next : row_base_q;
    fb_addr_d = !pix_en ? fb_addr_q : act_n ? col_q : '0;
    fb_rd_en_d = pix_en && act_n;
    s0_d = !pix_en ? s0_q : '{h_sync:      sync_level_f(h_n >= H_SYNC_LO, SYNC_POL),
                              v_sync:      sync_level_f(v_n >= V_SYNC_LO, SYNC_POL),
                              active:      act_n,
                              line_start:  act_n && x_n == '0,
                              frame_start: act_n && x_n == '0 && y_n == '0};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      started_q <= 1'b0;
      col_q <= '0;
      row_base_q <= '0;
      fb_addr_q <= '0;
      fb_rd_en_q <= 1'b0;
      s0_q <= IDLE;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      started_q <= started_d;
      col_q <= col_d;
      row_base_q <= row_base_d;
      fb_addr_q <= fb_addr_d;
      fb_rd_en_q <= fb_rd_en_d;
      s0_q <= s0_d;
    end
  end
  if (RD_LATENCY == 0) begin : g_nodly
    assign s_out = s0_q;
  end else begin : g_dly
    video_delay_line #(.DEPTH(RD_LATENCY), .W($bits(vid_sig_t)), .RST_VAL(IDLE)) u_dly (
      .clk(clk), .rst(rst), .en(pix_en), .d(s0_q), .q(s_out)
    );
  end
  assign fb_addr = fb_addr_q;
  assign fb_rd_en = fb_rd_en_q;
  assign h_sync = s_out.h_sync;
  assign v_sync = s_out.v_sync;
  assign active = s_out.active;
  assign line_start = s_out.line_start;
  assign frame_start = s_out.frame_start;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of raster timing, replication addressing, latency and reset
module tb_video_timing_gen;
  logic clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
  logic [14:0] a_addr, b_addr, c_addr;
  logic a_rd, a_hs, a_vs, a_act, a_ls, a_fs;
  logic b_rd, b_hs, b_vs, b_act, b_ls, b_fs;
  logic c_rd, c_hs, c_vs, c_act, c_ls, c_fs;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  video_timing_gen dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .fb_addr(a_addr), .fb_rd_en(a_rd), .h_sync(a_hs),
    .v_sync(a_vs), .active(a_act), .line_start(a_ls), .frame_start(a_fs));
  video_timing_gen #(.H_ACTIVE(8), .H_BACK(2), .H_FRONT(1), .H_SYNC(1), .V_ACTIVE(4), .V_BACK(1),
                     .V_FRONT(1), .V_SYNC(1), .SCALE_LOG2(1)) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .fb_addr(b_addr), .fb_rd_en(b_rd), .h_sync(b_hs),
    .v_sync(b_vs), .active(b_act), .line_start(b_ls), .frame_start(b_fs));
  video_timing_gen #(.H_ACTIVE(16), .H_BACK(4), .H_FRONT(2), .H_SYNC(3), .V_ACTIVE(6), .V_BACK(2),
                     .V_FRONT(1), .V_SYNC(2), .SYNC_POL(1'b1), .SCALE_LOG2(1), .RD_LATENCY(2)) dut_c (
    .clk(clk), .rst(rst), .pix_en(pix_en), .fb_addr(c_addr), .fb_rd_en(c_rd), .h_sync(c_hs),
    .v_sync(c_vs), .active(c_act), .line_start(c_ls), .frame_start(c_fs));

  // replicated address for the k-th read of a dut_b frame: 4-wide framebuffer, each texel 2x2
  function automatic int exp_b(input int k);
    int j;
    j = k % 32;
    return ((j / 8) >> 1) * 4 + ((j % 8) >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_en = 1'b0;
    step();
    tests++;
    if ({a_addr, a_rd, a_hs, a_vs, a_act, a_ls, a_fs} !== {15'd0, 6'b011000}) begin
      fails++;
      $display("FAIL reset_a: got %b required %b", {a_addr, a_rd, a_hs, a_vs, a_act, a_ls, a_fs}, {15'd0, 6'b011000});
    end
    tests++;
    if ({c_hs, c_vs, c_act, c_rd} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_c_pol: got %b required 0000", {c_hs, c_vs, c_act, c_rd});
    end
    tests++;
    if ({dut_b.h_cnt_q, dut_b.v_cnt_q, dut_b.row_base_q} !== '0) begin
      fails++;
      $display("FAIL reset_counters: h %0d v %0d row %0d required 0", dut_b.h_cnt_q, dut_b.v_cnt_q, dut_b.row_base_q);
    end
    rst = 1'b0;
  endtask

  task automatic test_reference();
    int n, act_c, hs_lo, rd_c, ls_c, vs_lo;
    do_reset();
    pix_en = 1'b1;
    n = 0;
    while (a_ls !== 1'b1 && n < 30000) begin
      step();
      n++;
    end
    tests++;
    if (n !== 26450) begin
      fails++;
      $display("FAIL ref_first_line_start: clocks %0d required 26450", n);
    end
    tests++;
    if (a_fs !== 1'b1) begin
      fails++;
      $display("FAIL ref_frame_start_coincident: got %b required 1", a_fs);
    end
    act_c = 0; hs_lo = 0; rd_c = 0; ls_c = 0; vs_lo = 0;
    for (int i = 0; i < 800; i++) begin
      act_c += int'(a_act);
      hs_lo += int'(!a_hs);
      rd_c += int'(a_rd);
      ls_c += int'(a_ls);
      vs_lo += int'(!a_vs);
      step();
    end
    tests++;
    if (act_c !== 640) begin fails++; $display("FAIL ref_active_width: got %0d required 640", act_c); end
    tests++;
    if (hs_lo !== 96) begin fails++; $display("FAIL ref_hsync_width: got %0d required 96", hs_lo); end
    tests++;
    if (rd_c !== 640) begin fails++; $display("FAIL ref_rd_count: got %0d required 640", rd_c); end
    tests++;
    if (ls_c !== 1 || vs_lo !== 0) begin
      fails++;
      $display("FAIL ref_ls_vs: line_start %0d vsync_low %0d required 1 and 0", ls_c, vs_lo);
    end
    tests++;
    if (a_ls !== 1'b1) begin fails++; $display("FAIL ref_line_period: line_start %b at 800 clocks required 1", a_ls); end
  endtask

  task automatic test_replication();
    int k, zero_bad;
    do_reset();
    pix_en = 1'b1;
    k = 0;
    zero_bad = 0;
    for (int t = 0; t < 200 && k < 40; t++) begin
      step();
      if (b_rd) begin
        tests++;
        if (b_addr !== 15'(exp_b(k))) begin
          fails++;
          $display("FAIL repl_addr[%0d]: got %0d required %0d", k, b_addr, exp_b(k));
        end
        k++;
      end else if (b_addr !== 15'd0) zero_bad++;
    end
    tests++;
    if (k !== 40) begin fails++; $display("FAIL repl_read_count: got %0d required 40", k); end
    tests++;
    if (zero_bad !== 0) begin fails++; $display("FAIL repl_idle_addr: %0d nonzero idle addresses required 0", zero_bad); end
  endtask

  task automatic test_pix_en();
    int k, dbl, addr_bad, hold_bad, r0, r1, f0;
    logic prev_rd, prev_ls;
    do_reset();
    k = 0; dbl = 0; addr_bad = 0; hold_bad = 0; r0 = -1; r1 = -1; f0 = -1;
    prev_rd = 1'b0;
    prev_ls = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      pix_en = (t % 2 == 1);
      step();
      if (b_rd && prev_rd) dbl++;
      if (b_rd) begin
        if (b_addr !== 15'(exp_b(k))) addr_bad++;
        k++;
      end
      if (!b_rd && prev_rd && b_addr !== 15'(exp_b(k - 1))) hold_bad++;
      if (b_ls && !prev_ls) begin
        if (r0 < 0) r0 = t;
        else if (r1 < 0) r1 = t;
      end
      if (!b_ls && prev_ls && f0 < 0) f0 = t;
      prev_rd = b_rd;
      prev_ls = b_ls;
    end
    tests++;
    if (k < 32) begin fails++; $display("FAIL pe_read_count: got %0d required at least 32", k); end
    tests++;
    if (dbl !== 0) begin fails++; $display("FAIL pe_rd_strobe: %0d back-to-back strobes required 0", dbl); end
    tests++;
    if (addr_bad !== 0) begin fails++; $display("FAIL pe_addr: %0d wrong addresses required 0", addr_bad); end
    tests++;
    if (hold_bad !== 0) begin fails++; $display("FAIL pe_hold: %0d addresses not held required 0", hold_bad); end
    tests++;
    if (r1 - r0 !== 24) begin fails++; $display("FAIL pe_line_period: got %0d required 24", r1 - r0); end
    tests++;
    if (f0 - r0 !== 2) begin fails++; $display("FAIL pe_strobe_width: got %0d required 2", f0 - r0); end
  endtask

  task automatic test_latency_polarity();
    int t_rd, t_act, t_fs, hs_hi, vs_hi, act_c, ls_c, fs_c, both_c;
    do_reset();
    pix_en = 1'b1;
    t_rd = -1; t_act = -1; t_fs = -1;
    hs_hi = 0; vs_hi = 0; act_c = 0; ls_c = 0; fs_c = 0; both_c = 0;
    for (int t = 1; t <= 600; t++) begin
      step();
      if (c_rd && t_rd < 0) t_rd = t;
      if (c_act && t_act < 0) t_act = t;
      if (c_fs && t_fs < 0) t_fs = t;
      if (t_fs > 0 && t < t_fs + 275) begin
        hs_hi += int'(c_hs);
        vs_hi += int'(c_vs);
        act_c += int'(c_act);
        ls_c += int'(c_ls);
        fs_c += int'(c_fs);
        both_c += int'(c_fs && c_ls);
      end
    end
    tests++;
    if (t_act - t_rd !== 2) begin fails++; $display("FAIL lat_active_delay: got %0d required 2", t_act - t_rd); end
    tests++;
    if (t_fs !== 57) begin fails++; $display("FAIL lat_first_frame_start: clock %0d required 57", t_fs); end
    tests++;
    if (hs_hi !== 33) begin fails++; $display("FAIL pol_hsync_high: got %0d required 33", hs_hi); end
    tests++;
    if (vs_hi !== 50) begin fails++; $display("FAIL pol_vsync_high: got %0d required 50", vs_hi); end
    tests++;
    if (act_c !== 96) begin fails++; $display("FAIL lat_active_count: got %0d required 96", act_c); end
    tests++;
    if ({ls_c, fs_c, both_c} !== {32'd6, 32'd1, 32'd1}) begin
      fails++;
      $display("FAIL lat_strobes: ls %0d fs %0d coincident %0d required 6 1 1", ls_c, fs_c, both_c);
    end
  endtask

  task automatic test_reset_mid();
    int n, ls_early;
    do_reset();
    pix_en = 1'b1;
    n = 0;
    while (!(dut_c.h_cnt_q == 5'd10 && dut_c.v_cnt_q == 4'd5) && n < 400) begin
      step();
      n++;
    end
    tests++;
    if (c_act !== 1'b1) begin fails++; $display("FAIL mid_pre_active: got %b required 1", c_act); end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({c_addr, c_rd, c_hs, c_vs, c_act, c_ls, c_fs} !== '0) begin
      fails++;
      $display("FAIL mid_async_outputs: got %b required all 0", {c_addr, c_rd, c_hs, c_vs, c_act, c_ls, c_fs});
    end
    tests++;
    if ({dut_c.h_cnt_q, dut_c.v_cnt_q} !== '0) begin
      fails++;
      $display("FAIL mid_async_counters: h %0d v %0d required 0", dut_c.h_cnt_q, dut_c.v_cnt_q);
    end
    step();
    rst = 1'b0;
    n = 0;
    ls_early = 0;
    while (c_fs !== 1'b1 && n < 400) begin
      step();
      n++;
      if (c_ls && !c_fs) ls_early++;
    end
    tests++;
    if (n !== 57) begin fails++; $display("FAIL mid_restart_frame_start: clocks %0d required 57", n); end
    tests++;
    if (ls_early !== 0) begin fails++; $display("FAIL mid_partial_line: %0d early line_starts required 0", ls_early); end
  endtask

  task automatic test_frame_wrap();
    int n;
    do_reset();
    pix_en = 1'b1;
    n = 0;
    while (!(dut_b.h_cnt_q == 4'd11 && dut_b.v_cnt_q == 3'd6) && n < 200) begin
      step();
      n++;
    end
    tests++;
    if (dut_b.row_base_q !== 15'd8 || b_vs !== 1'b0) begin
      fails++;
      $display("FAIL wrap_pre: row_base %0d vsync %b required 8 and 0", dut_b.row_base_q, b_vs);
    end
    step();
    tests++;
    if ({dut_b.h_cnt_q, dut_b.v_cnt_q, dut_b.row_base_q} !== '0) begin
      fails++;
      $display("FAIL wrap_counters: h %0d v %0d row %0d required 0", dut_b.h_cnt_q, dut_b.v_cnt_q, dut_b.row_base_q);
    end
    tests++;
    if (b_vs !== 1'b0) begin fails++; $display("FAIL wrap_vsync_delayed: got %b required 0", b_vs); end
    step();
    tests++;
    if (b_vs !== 1'b1) begin fails++; $display("FAIL wrap_vsync_release: got %b required 1", b_vs); end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_replication();
    test_pix_en();
    test_latency_polarity();
    test_reset_mid();
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
